// File: rtl/normalizer_arbiter.sv
// -----------------------------------------------------------------------------
// normalizer_arbiter
//
// Purpose:
//   Lets the ADD and MUL datapaths share one combinational normalizer.
//   A round-robin arbiter picks at most one requester per cycle and steers its
//   unnormalized exponent/fraction onto norm_calc_*. The normalizer result
//   (norm_*) comes back in the same cycle. It is written, with the tag and
//   the source ID, into a 2-entry FIFO that feeds the rounding stage.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   add_valid/add_ready           ADD request handshake
//   add_exponent/_fraction/_tag   ADD operands (fraction is xx.x(47))
//   mul_valid/mul_ready           MUL request handshake
//   mul_exponent/_fraction/_tag   MUL operands
//   norm_calc_exponent/_fraction  operands presented to the normalizer
//   norm_exponent/_fraction       normalizer result (combinational return)
//   out_valid/out_ready           FIFO head handshake toward rounding
//   out_exponent/_fraction/_tag   FIFO head payload
//   out_source                    FIFO head origin, 0 = ADD, 1 = MUL
//   occupancy                     FIFO entry count, 0..2
//
// Handshake semantics (all interfaces): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer keeps its payload
// stable while valid is high and ready is low. ready here depends only on
// registered state and on the other requester's valid. It never depends on
// out_ready.
// -----------------------------------------------------------------------------
module normalizer_arbiter #(
   parameter int TAG_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,

   input  logic                 add_valid,
   output logic                 add_ready,
   input  logic [9:0]           add_exponent,
   input  logic [48:0]          add_fraction,
   input  logic [TAG_WIDTH-1:0] add_tag,

   input  logic                 mul_valid,
   output logic                 mul_ready,
   input  logic [9:0]           mul_exponent,
   input  logic [48:0]          mul_fraction,
   input  logic [TAG_WIDTH-1:0] mul_tag,

   output logic [9:0]           norm_calc_exponent,
   output logic [48:0]          norm_calc_fraction,
   input  logic [9:0]           norm_exponent,
   input  logic [48:0]          norm_fraction,

   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [9:0]           out_exponent,
   output logic [48:0]          out_fraction,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic                 out_source,
   output logic [1:0]           occupancy
);

   // Source encoding, also used for the last-grant register.
   localparam logic SRC_ADD = 1'b0;
   localparam logic SRC_MUL = 1'b1;

   // FIFO storage, two entries addressed by 1-bit pointers.
   logic [9:0]           r_exp  [2];
   logic [48:0]          r_frac [2];
   logic [TAG_WIDTH-1:0] r_tag  [2];
   logic                 r_src  [2];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [1:0]           r_count;

   // Source of the most recent accept; reset to MUL so ADD wins first.
   logic                 r_last_grant;

   logic                 w_space;
   logic                 w_add_acc;
   logic                 w_mul_acc;
   logic                 w_push;
   logic                 w_pop;
   logic [TAG_WIDTH-1:0] w_push_tag;

   // Space comes only from the registered count. A pop in this cycle frees
   // a slot for the next cycle, not for this one.
   assign w_space = (r_count != 2'd2);

   // Round robin: a requester wins when it is alone, or when the other
   // requester was served last. The two readies are never both high while
   // both valids are high, so at most one handshake happens per cycle.
   assign add_ready = w_space && (!mul_valid || (r_last_grant == SRC_MUL));
   assign mul_ready = w_space && (!add_valid || (r_last_grant == SRC_ADD));

   assign w_add_acc = add_valid && add_ready;
   assign w_mul_acc = mul_valid && mul_ready;
   assign w_push    = w_add_acc || w_mul_acc;
   assign w_pop     = out_valid && out_ready;

   // ADD operands are the default. The normalizer input is therefore
   // defined in idle cycles too.
   assign norm_calc_exponent = w_mul_acc ? mul_exponent : add_exponent;
   assign norm_calc_fraction = w_mul_acc ? mul_fraction : add_fraction;
   assign w_push_tag         = w_mul_acc ? mul_tag      : add_tag;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            r_exp[i]  <= '0;
            r_frac[i] <= '0;
            r_tag[i]  <= '0;
            r_src[i]  <= 1'b0;
         end
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_count      <= 2'd0;
         r_last_grant <= SRC_MUL;
      end else begin
         if (w_push) begin
            r_exp[r_wr_ptr]  <= norm_exponent;
            r_frac[r_wr_ptr] <= norm_fraction;
            r_tag[r_wr_ptr]  <= w_push_tag;
            r_src[r_wr_ptr]  <= w_mul_acc ? SRC_MUL : SRC_ADD;
            r_wr_ptr         <= ~r_wr_ptr;
            r_last_grant     <= w_mul_acc ? SRC_MUL : SRC_ADD;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // The head is read straight from storage. It cannot change while it
   // waits for out_ready, because only a pop moves r_rd_ptr and the tail is
   // always a different slot when count is 1.
   assign out_valid    = (r_count != 2'd0);
   assign out_exponent = r_exp[r_rd_ptr];
   assign out_fraction = r_frac[r_rd_ptr];
   assign out_tag      = r_tag[r_rd_ptr];
   assign out_source   = r_src[r_rd_ptr];
   assign occupancy    = r_count;

endmodule

// File: tb/tb_normalizer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_normalizer_arbiter
//
// Drives normalizer_arbiter with directed scenarios and random traffic.
// A behavioural normalizer closes the norm_calc -> norm loop. The model of
// the block is an ordered queue of expected FIFO entries, packed as
// {source, tag, exponent, fraction}, plus the identity of the last winner.
// -----------------------------------------------------------------------------
module tb_normalizer_arbiter;

   localparam int TW = 4;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          add_valid = 1'b0, mul_valid = 1'b0, out_ready = 1'b0;
   logic [9:0]    add_exponent = '0, mul_exponent = '0;
   logic [48:0]   add_fraction = '0, mul_fraction = '0;
   logic [TW-1:0] add_tag = '0, mul_tag = '0;
   logic          add_ready, mul_ready, out_valid, out_source;
   logic [9:0]    norm_calc_exponent, norm_exponent, out_exponent;
   logic [48:0]   norm_calc_fraction, norm_fraction, out_fraction;
   logic [TW-1:0] out_tag;
   logic [1:0]    occupancy;

   normalizer_arbiter #(.TAG_WIDTH(TW)) dut (
      .clk(clk), .reset_n(reset_n),
      .add_valid(add_valid), .add_ready(add_ready), .add_exponent(add_exponent),
      .add_fraction(add_fraction), .add_tag(add_tag),
      .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_exponent(mul_exponent),
      .mul_fraction(mul_fraction), .mul_tag(mul_tag),
      .norm_calc_exponent(norm_calc_exponent), .norm_calc_fraction(norm_calc_fraction),
      .norm_exponent(norm_exponent), .norm_fraction(norm_fraction),
      .out_valid(out_valid), .out_ready(out_ready), .out_exponent(out_exponent),
      .out_fraction(out_fraction), .out_tag(out_tag), .out_source(out_source),
      .occupancy(occupancy)
   );

   // Behavioural normalizer: brings the leading one to bit 47 (format xx.x(47)).
   function automatic logic [58:0] nrm(input logic [9:0] e, input logic [48:0] f);
      logic [9:0]  ee;
      logic [48:0] ff;
      ee = e;
      ff = f;
      if (ff[48]) begin
         ff = ff >> 1;
         ee = ee + 10'd1;
      end else begin
         for (int i = 0; i < 48; i++) begin
            if (ff != '0 && !ff[47]) begin
               ff = ff << 1;
               ee = ee - 10'd1;
            end
         end
      end
      return {ee, ff};
   endfunction

   always_comb {norm_exponent, norm_fraction} = nrm(norm_calc_exponent, norm_calc_fraction);

   // scoreboard
   logic [63:0] exp_q[$];
   logic        grant_log[$];
   logic        model_last_mul = 1'b1;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic av, input logic mv, input logic ordy);
      add_valid    = av;
      mul_valid    = mv;
      out_ready    = ordy;
      add_exponent = 10'($urandom);
      mul_exponent = 10'($urandom);
      add_fraction = {17'($urandom), $urandom};
      mul_fraction = {17'($urandom), $urandom};
      add_tag      = TW'($urandom);
      mul_tag      = TW'($urandom);
   endtask

   // One clock cycle: inputs already driven just after the previous edge.
   // Checks happen at the falling edge. The model advances at the rising edge.
   task automatic cycle();
      logic        space, exp_ar, exp_mr, acc_add, acc_mul, pop;
      logic [63:0] head, add_ent, mul_ent;
      @(negedge clk);
      space  = (exp_q.size() != 2);
      exp_ar = space && (!mul_valid || model_last_mul);
      exp_mr = space && (!add_valid || !model_last_mul);
      check("add_ready", 64'(add_ready), 64'(exp_ar));
      check("mul_ready", 64'(mul_ready), 64'(exp_mr));
      check("occupancy", 64'(occupancy), 64'(exp_q.size()));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         check("out_source",   64'(out_source),   64'(head[63]));
         check("out_tag",      64'(out_tag),      64'(head[62:59]));
         check("out_exponent", 64'(out_exponent), 64'(head[58:49]));
         check("out_fraction", 64'(out_fraction), 64'(head[48:0]));
      end
      acc_add = add_valid && exp_ar;
      acc_mul = mul_valid && exp_mr;
      check("norm_calc_exponent", 64'(norm_calc_exponent),
            64'(acc_mul ? mul_exponent : add_exponent));
      check("norm_calc_fraction", 64'(norm_calc_fraction),
            64'(acc_mul ? mul_fraction : add_fraction));
      add_ent = {1'b0, add_tag, nrm(add_exponent, add_fraction)};
      mul_ent = {1'b1, mul_tag, nrm(mul_exponent, mul_fraction)};
      pop = (exp_q.size() != 0) && out_ready;
      @(posedge clk);
      if (pop) void'(exp_q.pop_front());
      if (acc_add) begin
         exp_q.push_back(add_ent);
         grant_log.push_back(1'b0);
         model_last_mul = 1'b0;
      end
      if (acc_mul) begin
         exp_q.push_back(mul_ent);
         grant_log.push_back(1'b1);
         model_last_mul = 1'b1;
      end
      #1;
   endtask

   // Assert reset, check the asynchronous clear, release just after an edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_exponent", 64'(out_exponent), 64'd0);
      check("rst_out_fraction", 64'(out_fraction), 64'd0);
      check("rst_out_tag_src", 64'({out_tag, out_source}), 64'd0);
      exp_q.delete();
      model_last_mul = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic [9:0]  snap_e;
      logic [48:0] snap_f;
      logic [TW:0] snap_ts;

      // Reset with both requesters valid; ADD must win first.
      drive(1'b1, 1'b1, 1'b1);
      do_reset();
      #2;
      check("first_add_ready", 64'(add_ready), 64'd1);
      check("first_mul_ready", 64'(mul_ready), 64'd0);
      cycle();
      repeat (3) begin drive(1'b0, 1'b0, 1'b1); cycle(); end

      // Single ADD request through the normalizer.
      drive(1'b1, 1'b0, 1'b0);
      add_exponent = 10'd130;
      add_fraction = 49'h0_4000_0000_0000;
      add_tag      = 4'd3;
      cycle();
      drive(1'b0, 1'b0, 1'b0);
      #2;
      check("single_valid",    64'(out_valid),    64'd1);
      check("single_exponent", 64'(out_exponent), 64'd129);
      check("single_fraction", 64'(out_fraction), 64'h0_8000_0000_0000);
      check("single_tag",      64'(out_tag),      64'd3);
      check("single_source",   64'(out_source),   64'd0);
      cycle();

      // Continuous contention from reset: ADD, MUL, ADD, MUL, ADD, MUL.
      do_reset();
      grant_log.delete();
      repeat (6) begin drive(1'b1, 1'b1, 1'b1); cycle(); end
      check("alt_count", 64'(grant_log.size()), 64'd6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++)
         check("alt_source", 64'(grant_log[i]), 64'(i % 2));
      repeat (3) begin drive(1'b0, 1'b0, 1'b1); cycle(); end

      // Backpressure: fill, hold stable, then a single pop frees one slot.
      repeat (2) begin drive(1'b1, 1'b1, 1'b0); cycle(); end
      drive(1'b1, 1'b1, 1'b0);
      #2;
      check("full_occupancy", 64'(occupancy), 64'd2);
      check("full_readies", 64'({add_ready, mul_ready}), 64'd0);
      snap_e  = out_exponent;
      snap_f  = out_fraction;
      snap_ts = {out_tag, out_source};
      cycle();
      repeat (3) begin drive(1'b1, 1'b1, 1'b0); cycle(); end
      #2;
      check("hold_exponent", 64'(out_exponent), 64'(snap_e));
      check("hold_fraction", 64'(out_fraction), 64'(snap_f));
      check("hold_tag_src",  64'({out_tag, out_source}), 64'(snap_ts));
      drive(1'b1, 1'b1, 1'b1);
      check("full_no_accept", 64'({add_ready, mul_ready}), 64'd0);
      cycle();
      drive(1'b1, 1'b1, 1'b0);
      #2;
      check("after_pop_occupancy", 64'(occupancy), 64'd1);
      check("after_pop_accept", 64'(add_ready || mul_ready), 64'd1);
      cycle();
      repeat (4) begin drive(1'b0, 1'b0, 1'b1); cycle(); end

      // Simultaneous push and pop at occupancy 1.
      drive(1'b1, 1'b0, 1'b0);
      add_tag = 4'd5;
      cycle();
      drive(1'b1, 1'b0, 1'b1);
      add_tag = 4'd9;
      cycle();
      drive(1'b0, 1'b0, 1'b0);
      #2;
      check("pushpop_occupancy", 64'(occupancy), 64'd1);
      check("pushpop_head_tag",  64'(out_tag),   64'd9);
      cycle();

      // Reset while full: entries discarded, ADD has priority again.
      drive(1'b0, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 1'b1, 1'b0);
      cycle();
      #2;
      check("prereset_occupancy", 64'(occupancy), 64'd2);
      drive(1'b1, 1'b1, 1'b1);
      do_reset();
      grant_log.delete();
      cycle();
      check("post_reset_grant", 64'(grant_log.size() == 1 && grant_log[0] == 1'b0), 64'd1);
      #2;
      check("post_reset_occupancy", 64'(occupancy), 64'd1);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/normalizer_arbiter.md
Name: normalizer_arbiter

Overview:
- Shares one combinational normalizer between the adder/subtractor path (ADD) and the multiplier path (MUL) of the pipelined FPU.
- Round-robin arbitration selects one requester per cycle and drives its unnormalized exponent/fraction to the normalizer.
- The normalizer's result is captured, with source ID and tag, into a 2-entry output FIFO that has a valid/ready interface toward rounding.

Parameters:
TAG_WIDTH, 4, width of the per-operation tag carried through unchanged

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
add_valid  input  1  ADD request valid
add_ready  output  1  ADD request accepted this cycle when add_valid high
add_exponent  input  10  ADD calculated exponent
add_fraction  input  49  ADD calculated fraction, xx.x(47) format
add_tag  input  TAG_WIDTH  ADD tag
mul_valid  input  1  MUL request valid
mul_ready  output  1  MUL request accepted this cycle when mul_valid high
mul_exponent  input  10  MUL calculated exponent
mul_fraction  input  49  MUL calculated fraction
mul_tag  input  TAG_WIDTH  MUL tag
norm_calc_exponent  output  10  exponent to normalizer
norm_calc_fraction  output  49  fraction to normalizer
norm_exponent  input  10  normalized exponent from normalizer (combinational return)
norm_fraction  input  49  normalized fraction from normalizer
out_valid  output  1  FIFO head valid
out_ready  input  1  downstream accepts head
out_exponent  output  10  head normalized exponent
out_fraction  output  49  head normalized fraction
out_tag  output  TAG_WIDTH  head tag
out_source  output  1  head origin: 0 = ADD, 1 = MUL
occupancy  output  2  FIFO entry count, 0..2

Behaviour:
- Reset (async assert, sync release):
  - FIFO count = 0 and out_valid = 0.
  - out_exponent, out_fraction, out_tag, out_source = 0.
  - last_grant = MUL, so ADD wins the first contention.
- space = (count != 2). This uses registered count only; there is no combinational path from out_ready to add_ready/mul_ready.
- add_ready = space && (!mul_valid || last_grant == MUL).
- mul_ready = space && (!add_valid || last_grant == ADD).
- These rules ensure at most one handshake per cycle.
- Accept = (add_valid && add_ready) || (mul_valid && mul_ready).
- On accept:
  - last_grant updates to the accepted source.
  - {norm_exponent, norm_fraction, tag, source} is written to the FIFO tail in the same cycle.
- Latency: result visible at out_* the cycle after accept, when the FIFO was empty or popping.
- Operand mux:
  - norm_calc_* = mul_* when (mul_valid && mul_ready), else add_*.
  - Defined in every cycle, including idle (ADD data).
- Pop = out_valid && out_ready; removes the head.
- FIFO behaviour:
  - Strict FIFO order.
  - out_* reflect the head entry and hold stable while out_valid && !out_ready.
  - Simultaneous push and pop: count unchanged. At count 1, the new entry becomes head the next cycle.
  - Count 2: both readies low for that cycle even if out_ready is high. A pop frees space for the next cycle.
  - Push at count 2 cannot occur. Pop at count 0 is ignored.
- Starvation freedom: under continuous contention, grants alternate ADD, MUL, ADD, … (while space allows).
- No arithmetic in this block. Exponent and fraction pass through bit-exact, and tags are never modified.
- Reset mid-operation: all FIFO entries discarded and out_valid drops immediately. In-flight requester data is not preserved; requesters must re-present.

Test Plan:
- Reset with add_valid = mul_valid = 1 held → out_valid = 0, occupancy = 0. After release, the first accept is ADD (add_ready = 1, mul_ready = 0).
- Single ADD request, with the team normalizer connected: exponent 130, fraction 49'h0_4000_0000_0000, tag 3 → next cycle out_valid = 1, out_exponent = 129, out_fraction = 49'h0_8000_0000_0000, out_tag = 3, out_source = 0.
- Both valid for 6 cycles, out_ready = 1 → accepted sources ADD, MUL, ADD, MUL, ADD, MUL; output order matches, with tags intact.
- out_ready = 0, both requesters streaming → occupancy reaches 2 after 2 accepts, then add_ready = mul_ready = 0. out_* remain stable. Raising out_ready for 1 cycle yields one pop, and a new accept occurs the following cycle.
- occupancy = 1, out_ready = 1, ADD request → pop and push in the same cycle; occupancy stays 1 and the new entry appears at the head the next cycle.
- reset_n asserted with occupancy = 2 → out_valid and occupancy go to 0 asynchronously. After release, no stale entry appears and ADD again has priority.
